// File: rtl/sigmoid_feeder_if.sv
// Stream bundle between the neuron-sum producer, the sigmoid feeder FIFO and the sigmoid block.
// The slave modport is the feeder's view. The master modport is the view of the surrounding logic.
interface sigmoid_feeder_if #(
  parameter int IDX_W = 6
) ();
  logic [31:0]      data_in;
  logic             valid_in;
  logic             last_in;
  logic             ready_in;
  logic [31:0]      data_out;
  logic             valid_out;
  logic             last_out;
  logic [IDX_W-1:0] index_out;
  logic             ready_out;

  modport slave (
    input  data_in, valid_in, last_in, ready_out,
    output ready_in, data_out, valid_out, last_out, index_out
  );

  modport master (
    output data_in, valid_in, last_in, ready_out,
    input  ready_in, data_out, valid_out, last_out, index_out
  );
endinterface

// File: rtl/sigmoid_feeder.sv
// FIFO front-end for the sigmoid activation: sanitises float_24_8 sums on entry,
// tags vector boundaries (with forced termination at MAX_LEN) and indexes elements on exit.
module sigmoid_feeder #(
  parameter int DEPTH   = 8,
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  sigmoid_feeder_if.slave       bus,
  output logic                  len_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [32:0]      mem_q [DEPTH];
  logic [32:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] in_len_q, in_len_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             len_err_q, len_err_d;

  logic        rdy_in, vld_out, wr_en, rd_en;
  logic        force_last, last_st;
  logic [31:0] clean;
  logic [32:0] head;

  always_comb begin
    rdy_in  = (count_q < CNT_W'(DEPTH)) && !reset;
    vld_out = (count_q != '0) && !reset;
    head    = mem_q[rd_ptr_q];
    wr_en   = bus.valid_in && rdy_in;
    rd_en   = vld_out && bus.ready_out;

    bus.ready_in  = rdy_in;
    bus.valid_out = vld_out;
    bus.data_out  = vld_out ? head[31:0] : '0;
    bus.last_out  = vld_out ? head[32] : 1'b0;
    bus.index_out = vld_out ? out_idx_q : '0;
    len_err       = len_err_q && !reset;

    // Denormals flush to +0; Inf/NaN saturate to +/-128.0 keeping the sign.
    unique case (bus.data_in[30:23])
      8'h00:   clean = '0;
      8'hFF:   clean = {bus.data_in[31], 8'd134, 23'd0};
      default: clean = bus.data_in;
    endcase

    force_last = (in_len_q == IDX_W'(MAX_LEN - 1)) && !bus.last_in;
    last_st    = bus.last_in || force_last;

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {last_st, clean};

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    in_len_d = in_len_q;
    if (wr_en) in_len_d = last_st ? '0 : in_len_q + 1'b1;

    out_idx_d = out_idx_q;
    if (rd_en) out_idx_d = head[32] ? '0 : out_idx_q + 1'b1;

    len_err_d = len_err_q || (wr_en && force_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_len_q  <= '0;
      out_idx_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      in_len_q  <= in_len_d;
      out_idx_q <= out_idx_d;
      len_err_q <= len_err_d;
    end
  end
endmodule

// File: tb/tb_sigmoid_feeder.sv
// Self-checking bench for sigmoid_feeder: random and directed traffic against a queue model.
module tb_sigmoid_feeder;
  localparam int DEPTH   = 8;
  localparam int MAX_LEN = 64;
  localparam int IDX_W   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic len_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sigmoid_feeder_if #(.IDX_W(IDX_W)) bus ();

  sigmoid_feeder #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .len_err (len_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          idx;
  } ent_t;

  typedef struct packed {
    logic             rdy;
    logic             vld;
    logic [31:0]      d;
    logic             l;
    logic [IDX_W-1:0] idx;
    logic             err;
  } obs_t;

  ent_t mq[$];
  int   m_len = 0;
  bit   m_err = 1'b0;

  function automatic logic [31:0] sanitize(logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (e == 0) return 32'h0;
    if (e == 255) return x[31] ? 32'hC300_0000 : 32'h4300_0000;
    return x;
  endfunction

  function automatic void model_update(bit wr, logic [31:0] d, bit l, bit rd);
    ent_t e;
    bit   forced;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      forced = (m_len == MAX_LEN - 1) && !l;
      e.d    = sanitize(d);
      e.l    = l || forced;
      e.idx  = m_len;
      if (forced) m_err = 1'b1;
      m_len = e.l ? 0 : m_len + 1;
      mq.push_back(e);
    end
  endfunction

  task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit r, output obs_t o);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.last_in   = l;
    bus.ready_out = r;
    #1;
    o.rdy = bus.ready_in;
    o.vld = bus.valid_out;
    o.d   = bus.data_out;
    o.l   = bus.last_out;
    o.idx = bus.index_out;
    o.err = len_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    cyc(1'b1, 32'h4040_0000, 1'b1, 1'b1, o);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b d=%h l=%b idx=%0d err=%b, want all zero",
               o.rdy, o.vld, o.d, o.l, o.idx, o.err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    obs_t o;
    cyc(1'b1, 32'h4040_0000, 1'b1, 1'b1, o);
    checks++;
    if (o.vld !== 1'b0 || o.rdy !== 1'b1) begin
      errors++;
      $display("FAIL single_pre: vld=%b rdy=%b want 0 1", o.vld, o.rdy);
    end
    model_update(1'b1, 32'h4040_0000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, o);
    checks++;
    if (o.vld !== 1'b1 || o.d !== 32'h4040_0000 || o.l !== 1'b1 || o.idx !== '0) begin
      errors++;
      $display("FAIL single_out: vld=%b d=%h l=%b idx=%0d want 1 40400000 1 0", o.vld, o.d, o.l, o.idx);
    end
    model_update(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, o);
    checks++;
    if (o.vld !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: vld=%b want 0", o.vld);
    end
  endtask

  task automatic test_fill();
    obs_t o;
    bit v, r, ev, er;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      v = (i < 10);
      r = (i >= 10);
      d = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      cyc(v, d, 1'b0, r, o);
      ev = mq.size() != 0;
      er = mq.size() < DEPTH;
      checks++;
      if (o.vld !== ev || o.rdy !== er) begin
        errors++;
        $display("FAIL fill_hs cyc %0d: vld=%b rdy=%b want %b %b", i, o.vld, o.rdy, ev, er);
      end
      if (ev) begin
        checks++;
        if (o.d !== mq[0].d || o.l !== mq[0].l || o.idx !== IDX_W'(mq[0].idx)) begin
          errors++;
          $display("FAIL fill_data cyc %0d: d=%h l=%b idx=%0d want %h %b %0d",
                   i, o.d, o.l, o.idx, mq[0].d, mq[0].l, mq[0].idx);
        end
      end
      model_update(v && er, d, 1'b0, r && ev);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    bit v, r, l, ev, er;
    logic [31:0] d;
    for (int i = 0; i < 44; i++) begin
      v = (i < 36);
      r = (i >= 4);
      l = (i == 35);
      d = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      cyc(v, d, l, r, o);
      ev = mq.size() != 0;
      er = mq.size() < DEPTH;
      checks++;
      if (o.vld !== ev || o.rdy !== er) begin
        errors++;
        $display("FAIL b2b_hs cyc %0d: vld=%b rdy=%b want %b %b", i, o.vld, o.rdy, ev, er);
      end
      if (ev) begin
        checks++;
        if (o.d !== mq[0].d || o.l !== mq[0].l || o.idx !== IDX_W'(mq[0].idx)) begin
          errors++;
          $display("FAIL b2b_data cyc %0d: d=%h l=%b idx=%0d want %h %b %0d",
                   i, o.d, o.l, o.idx, mq[0].d, mq[0].l, mq[0].idx);
        end
      end
      model_update(v && er, d, l, r && ev);
    end
  endtask

  task automatic test_maxlen();
    obs_t o;
    bit v, ev, er;
    int nrd = 0;
    logic [31:0] d;
    for (int i = 0; i < 76; i++) begin
      v = (i < 70);
      d = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      cyc(v, d, 1'b0, 1'b1, o);
      ev = mq.size() != 0;
      er = mq.size() < DEPTH;
      checks++;
      if (o.vld !== ev || o.rdy !== er || o.err !== m_err) begin
        errors++;
        $display("FAIL maxlen_hs cyc %0d: vld=%b rdy=%b err=%b want %b %b %b", i, o.vld, o.rdy, o.err, ev, er, m_err);
      end
      if (ev) begin
        checks++;
        if (o.d !== mq[0].d || o.l !== mq[0].l || o.idx !== IDX_W'(mq[0].idx)) begin
          errors++;
          $display("FAIL maxlen_data cyc %0d: d=%h l=%b idx=%0d want %h %b %0d",
                   i, o.d, o.l, o.idx, mq[0].d, mq[0].l, mq[0].idx);
        end
        if (nrd == 63 || nrd == 64) begin
          checks++;
          if (o.l !== (nrd == 63) || o.idx !== IDX_W'(nrd == 63 ? 63 : 0)) begin
            errors++;
            $display("FAIL maxlen_boundary read %0d: l=%b idx=%0d", nrd, o.l, o.idx);
          end
        end
        nrd++;
      end
      model_update(v && er, d, 1'b0, ev);
    end
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL maxlen_sticky: len_err=%b want 1", len_err);
    end
  endtask

  task automatic test_sanitize();
    obs_t o;
    bit v, r, l, ev, er;
    logic [31:0] d;
    logic [31:0] special [3];
    logic [31:0] want [3];
    special = '{32'h0000_0123, 32'h7F80_0000, 32'hFFC0_0000};
    want    = '{32'h0000_0000, 32'h4300_0000, 32'hC300_0000};
    for (int i = 0; i < 6; i++) begin
      v = (i < 3);
      d = v ? special[i] : 32'h0;
      cyc(v, d, 1'b0, !v, o);
      ev = mq.size() != 0;
      if (!v) begin
        checks++;
        if (o.vld !== 1'b1 || o.d !== want[i-3]) begin
          errors++;
          $display("FAIL sanitize_special %0d: vld=%b d=%h want 1 %h", i - 3, o.vld, o.d, want[i-3]);
        end
      end
      model_update(v, d, 1'b0, !v && ev);
    end
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d[30:23] = 8'h00;
        1: d[30:23] = 8'hFF;
        default: ;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 7) == 0);
      cyc(v, d, l, r, o);
      ev = mq.size() != 0;
      er = mq.size() < DEPTH;
      checks++;
      if (o.vld !== ev || o.rdy !== er || o.err !== m_err) begin
        errors++;
        $display("FAIL rand_hs cyc %0d: vld=%b rdy=%b err=%b want %b %b %b", i, o.vld, o.rdy, o.err, ev, er, m_err);
      end
      if (ev) begin
        checks++;
        if (o.d !== mq[0].d || o.l !== mq[0].l || o.idx !== IDX_W'(mq[0].idx)) begin
          errors++;
          $display("FAIL rand_data cyc %0d: d=%h l=%b idx=%0d want %h %b %0d",
                   i, o.d, o.l, o.idx, mq[0].d, mq[0].l, mq[0].idx);
        end
      end
      model_update(v && er, d, l, r && ev);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [31:0] d;
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1, o);
      model_update(1'b0, 32'h0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      d = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      cyc(1'b1, d, 1'b0, 1'b0, o);
      model_update(1'b1, d, 1'b0, 1'b0);
    end
    reset = 1'b1;
    cyc(1'b1, 32'h3F80_0000, 1'b0, 1'b1, o);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid_during: rdy=%b vld=%b d=%h l=%b idx=%0d err=%b want all zero",
               o.rdy, o.vld, o.d, o.l, o.idx, o.err);
    end
    reset = 1'b0;
    mq.delete();
    m_len = 0;
    m_err = 1'b0;
    d = 32'h3FC0_0000;
    cyc(1'b1, d, 1'b0, 1'b1, o);
    checks++;
    if (o.vld !== 1'b0 || o.err !== 1'b0 || o.rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: vld=%b err=%b rdy=%b want 0 0 1", o.vld, o.err, o.rdy);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, o);
    checks++;
    if (o.vld !== 1'b1 || o.d !== d || o.idx !== '0 || o.l !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: vld=%b d=%h idx=%0d l=%b want 1 %h 0 0", o.vld, o.d, o.idx, o.l, d);
    end
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_maxlen();
    test_sanitize();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sigmoid_feeder.md
Name: sigmoid_feeder

Overview:
Upstream stage of the sigmoid activation. It buffers neuron pre-activation sums in float_24_8 format in a small FIFO with valid/ready handshakes on both sides. Each sum is sanitised on entry: denormals are flushed to zero, and Inf/NaN are clamped to a saturating finite value. The block also tracks each vector's element index and last marker, and enforces a maximum vector length. Its output feeds the sigmoid block's data_in, one element per accepted transfer.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
MAX_LEN, 64, maximum elements per vector; a vector reaching this length without last_in is force-terminated.
IDX_W, 6, width of index_out; must satisfy 2**IDX_W >= MAX_LEN.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  32 (float_24_8)  neuron sum: {sgn, exp[7:0], man[22:0]}.
valid_in  input  1  data_in, last_in are valid.
last_in  input  1  final element of the current vector.
ready_in  output  1  FIFO can accept an element.
data_out  output  32 (float_24_8)  sanitised element to sigmoid.
valid_out  output  1  data_out, last_out, index_out are valid.
last_out  output  1  head element is the last of its vector.
index_out  output  IDX_W  position of the head element within its vector, starting at 0.
ready_out  input  1  downstream accepts the element.
len_err  output  1  sticky flag: a vector was force-terminated at MAX_LEN.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. While reset is high:
  - ready_in = 0 and valid_out = 0.
  - data_out = 0, last_out = 0, index_out = 0, len_err = 0.
  - FIFO pointers, occupancy count, input length counter and output index counter all clear.
  - Any in-flight or stored data is discarded. Reset asserted mid-vector leaves no partial state.
- Handshakes:
  - Write when valid_in & ready_in.
  - Read when valid_out & ready_out.
  - ready_in = (count < DEPTH) & ~reset, combinational from registered count.
  - valid_out = (count != 0).
  - data_out, last_out and index_out come from the FIFO head and hold stable while valid_out & ~ready_out.
- Latency: an element written at edge N is visible on data_out at edge N (i.e. in cycle N+1) when the FIFO was empty. There is no combinational pass-through from data_in to data_out.
- Simultaneous read and write:
  - When 0 < count < DEPTH: both occur and count is unchanged.
  - When full: ready_in = 0, so only the read occurs. The freed slot is offered in the next cycle.
  - When empty: only the write occurs.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, 0..DEPTH.
- Sanitising, applied on write; what is stored is what is emitted:
  - exp == 0: store 32'h0, sign cleared.
  - exp == 255: store {sgn, 8'd134, 23'd0}, i.e. ±128.0, which saturates the sigmoid.
  - Otherwise: pass unchanged.
- Input length counter (0..MAX_LEN-1):
  - Increments on each write; clears on a write with last_in or on forced last.
  - Forced last: if a write occurs with counter == MAX_LEN-1 and last_in = 0, the stored last bit is 1, len_err sets, and the counter clears.
  - len_err clears only on reset.
- Output index counter: index_out equals the number of reads since the last read with last_out = 1. It clears on a read with last_out = 1 and increments on any other read.
- Stored entry width: 33 bits, {last, float_24_8}.

Test Plan:
- Reset, then write 3.0 (32'h40400000) with last_in = 1, ready_out = 1 -> valid_out = 1 the next cycle; data_out = 32'h40400000, last_out = 1, index_out = 0; then valid_out = 0.
- Hold ready_out = 0 and write 10 elements at DEPTH = 8 -> ready_in drops after 8 writes. Raise ready_out -> elements emerge in order with index_out 0..7, and ready_in reasserts one cycle after the first read.
- Stream with valid_in and ready_out both held high (valid_in high every cycle), with the FIFO at count = 4 -> one write and one read per cycle, count stays 4, no element lost or duplicated.
- Write 32'h00000123, 32'h7F800000 and 32'hFFC00000 -> outputs 32'h00000000, 32'h43000000 and 32'hC3000000 respectively.
- MAX_LEN = 64: send 70 elements with no last_in -> element 63 is emitted with last_out = 1 and len_err = 1; element 64 has index_out = 0; len_err stays 1.
- Assert reset for 1 cycle with 5 entries queued mid-vector -> valid_out = 0 and len_err = 0; the next written element emerges with index_out = 0.
